// File: rtl/code_to_num.sv
// Seven-segment to number converter.
// Takes three packed segment codes (hundreds, tens, units) and decodes them
// one digit per cycle. It produces the binary value (0..999), the BCD digits
// and an error flag. Requests and results use valid/ready handshakes.
module code_to_num #(
  parameter bit IGNORE_DP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] seg_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  value,
  output logic [11:0] bcd,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [23:0] shreg;
  logic [9:0]  acc;
  logic [11:0] bcd_r;
  logic        err_r;
  logic [1:0]  cnt;
  // Every digit decoded so far was a blank, so a further blank is still a leading blank.
  logic        lead;

  logic        accept;
  logic        take_res;
  logic        last_digit;

  logic [5:0]  dec_word;
  logic        dig_ok;
  logic        dig_blank;
  logic [3:0]  dig;
  logic        dig_err;

  // Returns {recognised, blank, digit}. An unknown code gives {0, 0, 0}.
  function automatic logic [5:0] decode_seg(input logic [7:0] code);
    logic [7:0] c;
    c = IGNORE_DP ? {code[7:1], 1'b0} : code;
    case (c)
      8'hfc:   decode_seg = {1'b1, 1'b0, 4'd0};
      8'h60:   decode_seg = {1'b1, 1'b0, 4'd1};
      8'hda:   decode_seg = {1'b1, 1'b0, 4'd2};
      8'hf2:   decode_seg = {1'b1, 1'b0, 4'd3};
      8'h66:   decode_seg = {1'b1, 1'b0, 4'd4};
      8'hb6:   decode_seg = {1'b1, 1'b0, 4'd5};
      8'hbe:   decode_seg = {1'b1, 1'b0, 4'd6};
      8'he0:   decode_seg = {1'b1, 1'b0, 4'd7};
      8'hfe:   decode_seg = {1'b1, 1'b0, 4'd8};
      8'hf6:   decode_seg = {1'b1, 1'b0, 4'd9};
      8'h00:   decode_seg = {1'b1, 1'b1, 4'd0};
      default: decode_seg = {1'b0, 1'b0, 4'd0};
    endcase
  endfunction

  // acc*10 + d built from shifts and adds; the running value never exceeds 99
  // before the last step, so the result always fits in 10 bits.
  function automatic logic [9:0] mul10_add(input logic [9:0] a, input logic [3:0] d);
    mul10_add = {a[6:0], 3'b000} + {a[8:0], 1'b0} + {6'd0, d};
  endfunction

  assign accept     = in_valid && (state == IDLE);
  assign take_res   = out_ready && (state == DONE);
  assign last_digit = (cnt == 2'd2);

  // Decode the digit currently at the top of the shift register.
  always_comb begin
    dec_word  = decode_seg(shreg[23:16]);
    dig_ok    = dec_word[5];
    dig_blank = dec_word[4];
    dig       = dec_word[3:0];
    dig_err   = 1'b0;
    if (!dig_ok) begin
      dig_err = 1'b1;
    end else if (dig_blank && !(lead && !last_digit)) begin
      dig_err = 1'b1;
    end
  end

  // State register; reset takes priority over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = DEC;
        end
      end
      DEC: begin
        if (last_digit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request, then do one digit per DEC cycle (hundreds first).
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= 24'd0;
      acc   <= 10'd0;
      bcd_r <= 12'd0;
      err_r <= 1'b0;
      cnt   <= 2'd0;
      lead  <= 1'b1;
    end else if (accept) begin
      shreg <= seg_code;
      acc   <= 10'd0;
      bcd_r <= 12'd0;
      err_r <= 1'b0;
      cnt   <= 2'd0;
      lead  <= 1'b1;
    end else if (state == DEC) begin
      shreg <= {shreg[15:0], 8'h00};
      acc   <= mul10_add(acc, dig);
      bcd_r <= {bcd_r[7:0], dig};
      err_r <= err_r | dig_err;
      cnt   <= cnt + 2'd1;
      lead  <= lead & dig_ok & dig_blank;
    end
  end

  assign value = acc;
  assign bcd   = bcd_r;
  assign err   = err_r;

  // Results only move while decoding; nothing can change them in DONE.
  logic unused_ok;
  assign unused_ok = take_res;

endmodule

// File: tb/tb_code_to_num.sv
// Directed bench for code_to_num. Two instances share all inputs: one with
// the decimal point masked (default) and one with it significant.
module tb_code_to_num;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [23:0] seg_code;
  logic        out_ready;

  logic        in_ready1, out_valid1, err1;
  logic [9:0]  value1;
  logic [11:0] bcd1;
  logic        in_ready0, out_valid0, err0;
  logic [9:0]  value0;
  logic [11:0] bcd0;

  int total;
  int bad;

  code_to_num #(.IGNORE_DP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .seg_code(seg_code), .out_valid(out_valid1), .out_ready(out_ready),
    .value(value1), .bcd(bcd1), .err(err1)
  );

  code_to_num #(.IGNORE_DP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .seg_code(seg_code), .out_valid(out_valid0), .out_ready(out_ready),
    .value(value0), .bcd(bcd0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble seg_code to show it is ignored.
  task automatic accept(input logic [23:0] code);
    chk("in_ready_before", {31'd0, in_ready1}, 32'd1);
    seg_code = code;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seg_code = 24'h5a5a5a;
    chk("in_ready_after", {31'd0, in_ready1}, 32'd0);
  endtask

  // Three DEC cycles; the result is visible after the third decode edge.
  task automatic wait_done(input string tag);
    step();
    chk({tag, "_ov_e1"}, {31'd0, out_valid1}, 32'd0);
    step();
    chk({tag, "_ov_e2"}, {31'd0, out_valid1}, 32'd0);
    step();
    chk({tag, "_ov_e3"}, {31'd0, out_valid1}, 32'd1);
    chk({tag, "_ov0_e3"}, {31'd0, out_valid0}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [9:0] v1, input logic [11:0] b1,
                           input logic e1, input logic [9:0] v0, input logic e0);
    chk({tag, "_value"}, {22'd0, value1}, {22'd0, v1});
    chk({tag, "_bcd"}, {20'd0, bcd1}, {20'd0, b1});
    chk({tag, "_err"}, {31'd0, err1}, {31'd0, e1});
    chk({tag, "_value_dp"}, {22'd0, value0}, {22'd0, v0});
    chk({tag, "_err_dp"}, {31'd0, err0}, {31'd0, e0});
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, {31'd0, out_valid1}, 32'd0);
    chk({tag, "_ir_after"}, {31'd0, in_ready1}, 32'd1);
  endtask

  task automatic convert(input string tag, input logic [23:0] code,
                         input logic [9:0] v1, input logic [11:0] b1, input logic e1,
                         input logic [9:0] v0, input logic e0);
    accept(code);
    wait_done(tag);
    check_res(tag, v1, b1, e1, v0, e0);
    take(tag);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    seg_code  = 24'h000000;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_value", {22'd0, value1}, 32'd0);
    chk("rst_bcd", {20'd0, bcd1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);

    convert("c234", 24'hdaf266, 10'd234, 12'h234, 1'b0, 10'd234, 1'b0);
    convert("c000", 24'h0000fc, 10'd0, 12'h000, 1'b0, 10'd0, 1'b0);
    convert("c010", 24'h006000, 10'd10, 12'h010, 1'b1, 10'd10, 1'b1);
    convert("c100", 24'h6000fc, 10'd100, 12'h100, 1'b1, 10'd100, 1'b1);
    convert("c999", 24'hf6f6f7, 10'd999, 12'h999, 1'b0, 10'd990, 1'b1);
    convert("blank3", 24'h000000, 10'd0, 12'h000, 1'b1, 10'd0, 1'b1);
    convert("bad_h", 24'h12f266, 10'd34, 12'h034, 1'b1, 10'd34, 1'b1);

    // Back-pressure: hold out_ready low; in_valid pulses must be ignored.
    accept(24'hfeb6e0);
    wait_done("stall");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      seg_code = 24'hdaf266;
      step();
      chk("stall_ov", {31'd0, out_valid1}, 32'd1);
      chk("stall_ir", {31'd0, in_ready1}, 32'd0);
      chk("stall_value", {22'd0, value1}, 32'd857);
      chk("stall_bcd", {20'd0, bcd1}, 32'h857);
      chk("stall_err", {31'd0, err1}, 32'd0);
    end
    in_valid = 1'b0;
    take("stall");

    // Reset during the second DEC cycle aborts the conversion.
    accept(24'hbefcf2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ir", {31'd0, in_ready1}, 32'd1);
    chk("abort_ov", {31'd0, out_valid1}, 32'd0);
    chk("abort_value", {22'd0, value1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_ov_idle", {31'd0, out_valid1}, 32'd0);
    end
    convert("c603", 24'hbefcf2, 10'd603, 12'h603, 1'b0, 10'd603, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
